// File: rtl/mixcolumns_iter.sv
// Iterative AES MixColumns / InvMixColumns with valid/ready handshakes on both sides.
// A captured state is transformed COLS_PER_CYCLE columns per cycle, then held until released.
//
//   state | meaning
//   IDLE  | ready for a new state; last result still visible on state_out
//   CALC  | transforming one column group per cycle
//   HOLD  | result presented, waiting for out_ready

module mixcolumns_iter #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INVERSE_EN     = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] IDX_STEP = 2'(COLS_PER_CYCLE);

    state_t         state_q, state_d;
    logic [1:0]     col_idx_q, col_idx_d;
    logic [127:0]   work_q, work_d;
    logic [127:0]   res_q, res_d;
    logic [127:0]   out_q, out_d;
    logic           mode_q, mode_d;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0]  s  [4];
        logic [7:0]  x2 [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            s[i]  = c[8*i +: 8];
            x2[i] = xt(s[i]);
        end
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = x2[i] ^ x2[(i+1)%4] ^ s[(i+1)%4] ^ s[(i+2)%4] ^ s[(i+3)%4];
        end
        return r;
    endfunction

    // 9 = 8+1, b = 8+2+1, d = 8+4+1, e = 8+4+2, all from one xtime chain per byte
    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0]  s  [4];
        logic [7:0]  m9 [4];
        logic [7:0]  mb [4];
        logic [7:0]  md [4];
        logic [7:0]  me [4];
        logic [7:0]  x2, x4, x8;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            s[i]  = c[8*i +: 8];
            x2    = xt(s[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ s[i];
            mb[i] = x8 ^ x2 ^ s[i];
            md[i] = x8 ^ x4 ^ s[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
        end
        return r;
    endfunction

    logic [1:0]  lane_idx [COLS_PER_CYCLE];
    logic [31:0] lane_out [COLS_PER_CYCLE];

    generate
        for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
            logic [31:0] col_in;
            logic [31:0] col_fwd;
            assign lane_idx[g] = col_idx_q + 2'(g);
            assign col_in      = work_q[{lane_idx[g], 5'b0} +: 32];
            assign col_fwd     = mix_fwd(col_in);
            if (INVERSE_EN) begin : g_inv
                assign lane_out[g] = mode_q ? mix_inv(col_in) : col_fwd;
            end else begin : g_fwd_only
                assign lane_out[g] = col_fwd;
            end
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        work_d    = work_q;
        res_d     = res_q;
        out_d     = out_q;
        mode_d    = mode_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    work_d    = state_in;
                    mode_d    = INVERSE_EN ? mode : 1'b0;
                    col_idx_d = 2'd0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    res_d[{lane_idx[g], 5'b0} +: 32] = lane_out[g];
                end
                col_idx_d = col_idx_q + IDX_STEP;
                // res_d already includes this group, so the last group publishes directly
                if (col_idx_q == LAST_IDX) begin
                    out_d   = res_d;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_idx_q <= 2'd0;
            work_q    <= '0;
            res_q     <= '0;
            out_q     <= '0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            work_q    <= work_d;
            res_q     <= res_d;
            out_q     <= out_d;
            mode_q    <= mode_d;
        end
    end

    assign state_out = out_q;

endmodule

// File: tb/tb_mixcolumns_iter.sv
// Bench for mixcolumns_iter: four instances (1/2/4 columns per cycle, and forward-only),
// a GF(2^8) matrix reference model with a handshake timing model, and directed vectors.

module tb_mixcolumns_iter;

    localparam int NI = 4;
    localparam int CPC  [NI] = '{1, 2, 4, 1};
    localparam bit INVP [NI] = '{1'b1, 1'b1, 1'b1, 1'b0};

    localparam logic [127:0] VEC_A = 128'h4c31262d_d5d4d4d4_5c220af2_455313db;
    localparam logic [127:0] VEC_B = 128'hf8bd7e4d_d6d7d5d5_9d58dc9f_bca14d8e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [NI-1:0]          in_valid;
    logic [NI-1:0]          mode;
    logic [NI-1:0]          out_ready;
    logic [NI-1:0][127:0]   state_in;
    wire  [NI-1:0]          in_ready;
    wire  [NI-1:0]          out_valid;
    wire  [NI-1:0]          busy;
    wire  [NI-1:0][127:0]   state_out;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            mixcolumns_iter #(
                .COLS_PER_CYCLE(CPC[g]),
                .INVERSE_EN    (INVP[g])
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .in_valid (in_valid[g]),
                .in_ready (in_ready[g]),
                .mode     (mode[g]),
                .state_in (state_in[g]),
                .out_valid(out_valid[g]),
                .out_ready(out_ready[g]),
                .state_out(state_out[g]),
                .busy     (busy[g])
            );
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc ^= gmul(cf[(j - row + 4) % 4], s[32*c + 8*j +: 8]);
                end
                r[32*c + 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    // Handshake model: accept in idle, result after 4/CPC edges, hold until out_ready.
    int           m_phase [NI];
    int           m_cnt   [NI];
    logic [127:0] m_res   [NI];
    logic [127:0] m_out   [NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_phase[i] = 0;
            m_cnt[i]   = 0;
            m_res[i]   = '0;
            m_out[i]   = '0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_phase[i] <= 0;
                m_cnt[i]   <= 0;
                m_out[i]   <= '0;
            end else begin
                case (m_phase[i])
                    0: if (in_valid[i]) begin
                        m_phase[i] <= 1;
                        m_cnt[i]   <= 4 / CPC[i];
                        m_res[i]   <= ref_mix(state_in[i], INVP[i] ? mode[i] : 1'b0);
                    end
                    1: if (m_cnt[i] == 1) begin
                        m_phase[i] <= 2;
                        m_out[i]   <= m_res[i];
                    end else begin
                        m_cnt[i] <= m_cnt[i] - 1;
                    end
                    default: if (out_ready[i]) m_phase[i] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("u%0d_in_ready", i),  128'(in_ready[i]),  128'(m_phase[i] == 0));
                chk($sformatf("u%0d_out_valid", i), 128'(out_valid[i]), 128'(m_phase[i] == 2));
                chk($sformatf("u%0d_busy", i),      128'(busy[i]),      128'(m_phase[i] != 0));
                chk($sformatf("u%0d_state_out", i), state_out[i],       m_out[i]);
            end
        end
    end

    task automatic run_vec(input int g, input logic [127:0] d, input logic md,
                           output logic [127:0] res, output int lat);
        @(negedge clk);
        in_valid[g] = 1'b1;
        state_in[g] = d;
        mode[g]     = md;
        @(posedge clk);
        @(negedge clk);
        in_valid[g] = 1'b0;
        state_in[g] = {$urandom(), $urandom(), $urandom(), $urandom()};
        mode[g]     = 1'($urandom());
        lat = 0;
        while (!out_valid[g] && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid[g]) chk($sformatf("u%0d_out_valid_timeout", g), 128'(out_valid[g]), 128'd1);
        res = state_out[g];
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r, f, v, hold_val;
        logic [127:0] pats [2];
        int lat;
        int g;

        rst       = 1'b1;
        in_valid  = '0;
        mode      = '0;
        out_ready = '1;
        state_in  = '0;
        pats[0]   = {16{8'h01}};
        pats[1]   = {16{8'hc6}};

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d_rst_in_ready", i),  128'(in_ready[i]),  128'd1);
            chk($sformatf("u%0d_rst_out_valid", i), 128'(out_valid[i]), 128'd0);
            chk($sformatf("u%0d_rst_busy", i),      128'(busy[i]),      128'd0);
            chk($sformatf("u%0d_rst_state_out", i), state_out[i],       128'd0);
        end
        chk_en = 1'b1;
        rst    = 1'b0;

        chk("ref_pin_fwd", ref_mix(VEC_A, 1'b0), VEC_B);
        chk("ref_pin_inv", ref_mix(VEC_B, 1'b1), VEC_A);

        // forward and inverse known vector, all three widths
        for (int i = 0; i < 3; i++) begin
            run_vec(i, VEC_A, 1'b0, r, lat);
            chk($sformatf("u%0d_fwd_res", i), r, VEC_B);
            chk($sformatf("u%0d_fwd_lat", i), 128'(lat), 128'(4 / CPC[i]));
            run_vec(i, VEC_B, 1'b1, r, lat);
            chk($sformatf("u%0d_inv_res", i), r, VEC_A);
            chk($sformatf("u%0d_inv_lat", i), 128'(lat), 128'(4 / CPC[i]));
        end

        // fixed points in both modes
        for (int i = 0; i < NI; i++) begin
            for (int p = 0; p < 2; p++) begin
                for (int md = 0; md < 2; md++) begin
                    run_vec(i, pats[p], 1'(md), r, lat);
                    chk($sformatf("u%0d_fixed_p%0d_m%0d", i, p, md), r, pats[p]);
                end
            end
        end

        // forward-only build ignores mode
        run_vec(3, VEC_A, 1'b1, r, lat);
        chk("u3_noinv_res", r, VEC_B);
        chk("u3_noinv_lat", 128'(lat), 128'd4);

        // backpressure on the 2-column instance
        out_ready[1] = 1'b0;
        run_vec(1, VEC_A, 1'b0, r, lat);
        chk("bp_first_res", r, VEC_B);
        hold_val = state_out[1];
        for (int k = 0; k < 10; k++) begin
            in_valid[1] = 1'b1;
            state_in[1] = VEC_B;
            mode[1]     = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid[1]), 128'd1);
            chk("bp_state_out_stable", state_out[1], hold_val);
            chk("bp_in_ready", 128'(in_ready[1]), 128'd0);
        end
        out_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 128'(in_ready[1]), 128'd1);
        chk("bp_release_out_valid", 128'(out_valid[1]), 128'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        chk("bp_second_busy", 128'(busy[1]), 128'd1);
        lat = 0;
        while (!out_valid[1] && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("bp_second_valid", 128'(out_valid[1]), 128'd1);
        chk("bp_second_res", state_out[1], VEC_A);
        repeat (3) @(posedge clk);

        // reset during the second CALC cycle of the 1-column instance
        @(negedge clk);
        in_valid[0] = 1'b1;
        state_in[0] = VEC_A;
        mode[0]     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_state_out", state_out[0], 128'd0);
        chk("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("mid_rst_busy", 128'(busy[0]), 128'd0);
        chk("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("mid_rst_no_stale_valid", 128'(out_valid[0]), 128'd0);
            chk("mid_rst_no_stale_data", state_out[0], 128'd0);
        end

        // random round trips
        for (int n = 0; n < 1000; n++) begin
            g = n % 3;
            v = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_vec(g, v, 1'b0, f, lat);
            run_vec(g, f, 1'b1, r, lat);
            chk($sformatf("u%0d_roundtrip", g), r, v);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
